// File: rtl/bcd_display_scanner.sv
// bcd_display_scanner: iterative binary-to-BCD converter (shift-add-3) feeding a
// time-multiplexed common-segment seven-segment display.
// Optional feature macro: DISPLAY_LZB_EN enables leading-zero blanking.
module bcd_display_scanner #(
    parameter int unsigned WIDTH    = 10,
    parameter int unsigned DIGITS   = 3,
    parameter int unsigned SCAN_DIV = 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  num,
    input  logic              load,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] an
);

    localparam int unsigned BW = 4 * DIGITS;
    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StCommit
    } state_e;

    // Conversion state
    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [BW-1:0]  bcd_q, bcd_d;
    logic [BW-1:0]  bcd_adj;
    logic           acc_q, acc_d;
    logic [BW-1:0]  disp_q, disp_d;
    logic           valid_q, valid_d;
    logic           ovf_q, ovf_d;
    logic           done_q, done_d;
    logic           busy_q, busy_d;

    // Scan state
    logic [PW-1:0]     pre_q, pre_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [6:0]        seg_q, seg_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic [3:0]        cur_digit;
    logic              blank;

    // Segment pattern {g,f,e,d,c,b,a}; codes above 9 never reach the display.
    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111101;
            4'd7:    s = 7'b0000111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1101111;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    // Next-state logic for the load/shift/commit conversion FSM
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        acc_d   = acc_q;
        disp_d  = disp_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;

        // Add-3 correction applied before every shift
        bcd_adj = bcd_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (load) begin
                    bin_d   = num;
                    bcd_d   = '0;
                    acc_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                bcd_d = {bcd_adj[BW-2:0], bin_q[WIDTH-1]};
                bin_d = bin_q << 1;
                // A carry out of the top digit means the value is >= 10^DIGITS
                if (bcd_adj[BW-1]) begin
                    acc_d = 1'b1;
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = StCommit;
                end
            end
            StCommit: begin
                disp_d  = bcd_q;
                ovf_d   = acc_q;
                valid_d = 1'b1;
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    // Conversion FSM and its registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bin_q   <= '0;
            bcd_q   <= '0;
            acc_q   <= 1'b0;
            disp_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            acc_q   <= acc_d;
            disp_q  <= disp_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    // Free-running prescaler; the digit index steps on its terminal count
    always_comb begin
        pre_d = pre_q + PW'(1);
        idx_d = idx_q;
        if (pre_q == PW'(SCAN_DIV - 1)) begin
            pre_d = '0;
            idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
        end
    end

    // Scanner counters, never disturbed by conversion activity
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
            idx_q <= '0;
        end else begin
            pre_q <= pre_d;
            idx_q <= idx_d;
        end
    end

`ifdef DISPLAY_LZB_EN
    logic [DIGITS-1:0] lead_zero;
    logic              seen_nz;

    // Mark digits above the most significant nonzero one; units always shown
    always_comb begin
        seen_nz   = 1'b0;
        lead_zero = '0;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            if (disp_q[4*i +: 4] != 4'd0) begin
                seen_nz = 1'b1;
            end
            lead_zero[i] = !seen_nz && (i != 0);
        end
    end
`endif

    // Select the scanned digit and build the next segment/enable pattern
    always_comb begin
        cur_digit = 4'd0;
        blank     = 1'b0;
        an_d      = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (IW'(i) == idx_q) begin
                cur_digit = disp_q[4*i +: 4];
`ifdef DISPLAY_LZB_EN
                blank     = lead_zero[i];
`endif
                an_d[i]   = valid_q;
            end
        end
        seg_d = (valid_q && !blank) ? seg_of(cur_digit) : 7'b0000000;
    end

    // Display output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= '0;
            an_q  <= '0;
        end else begin
            seg_q <= seg_d;
            an_q  <= an_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = ovf_q;
    assign seg      = seg_q;
    assign an       = an_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Scoreboard bench for bcd_display_scanner (WIDTH=10, DIGITS=3, SCAN_DIV=4).
module tb_bcd_display_scanner;

    localparam int unsigned WIDTH    = 10;
    localparam int unsigned DIGITS   = 3;
    localparam int unsigned SCAN_DIV = 4;

`ifdef DISPLAY_LZB_EN
    localparam logic [6:0] LZ = 7'h00;
`else
    localparam logic [6:0] LZ = 7'h3F;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              load = 1'b0;
    logic [WIDTH-1:0]  num = '0;
    logic              busy;
    logic              done;
    logic              overflow;
    logic [6:0]        seg;
    logic [DIGITS-1:0] an;

    bcd_display_scanner #(
        .WIDTH   (WIDTH),
        .DIGITS  (DIGITS),
        .SCAN_DIV(SCAN_DIV)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .num     (num),
        .load    (load),
        .busy    (busy),
        .done    (done),
        .overflow(overflow),
        .seg     (seg),
        .an      (an)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            ovf;
        logic [2:0][6:0] segs;   // [0] = units
        time             t_load;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_busy = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: on each done pulse pop the expected result and check the display
    initial begin
        exp_t e;
        int   lat;
        forever begin
            @(negedge clk);
            if (rst_n && done === 1'b1) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 32'(done), 32'(0));
                end else begin
                    mon_busy = 1'b1;
                    e = q.pop_front();
                    lat = int'(($time - e.t_load - 5) / 10);
                    chk("done_latency", 32'(lat), 32'(11));
                    chk("overflow", 32'(overflow), 32'(e.ovf));
                    for (int c = 0; c < 14; c++) begin
                        @(negedge clk);
                        if (!rst_n) break;
                        chk("done_single_pulse", 32'(done), 32'(0));
                        chk("an_onehot", 32'($onehot(an)), 32'(1));
                        for (int d = 0; d < 3; d++) begin
                            if (an[d]) chk($sformatf("seg_digit%0d", d), 32'(seg), 32'(e.segs[d]));
                        end
                    end
                    mon_busy = 1'b0;
                end
            end
        end
    end

    task automatic do_load(input logic [WIDTH-1:0] v, input logic ovf,
                           input logic [2:0][6:0] segs, input bit push);
        exp_t e;
        @(negedge clk);
        num  = v;
        load = 1'b1;
        @(posedge clk);
        if (push) begin
            e.ovf    = ovf;
            e.segs   = segs;
            e.t_load = $time;
            q.push_back(e);
        end
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((q.size() != 0 || mon_busy) && n < 80) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 32'(n < 80), 32'(1));
    endtask

    // Stimulus
    initial begin
        logic [2:0] prev;
        int         run;
        int         ntrans;
        bit         first;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset: everything quiet and blank
        repeat (20) begin
            @(negedge clk);
            chk("idle_outputs", 32'({busy, done, overflow, seg, an}), 32'(0));
        end

        // 307
        do_load(10'd307, 1'b0, {7'h4F, 7'h3F, 7'h07}, 1'b1);
        wait_drain();

        // Scan order and hold time
        @(negedge clk);
        prev   = an;
        run    = 1;
        ntrans = 0;
        first  = 1'b1;
        repeat (30) begin
            @(negedge clk);
            chk("scan_onehot", 32'($onehot(an)), 32'(1));
            if (an == prev) begin
                run++;
            end else begin
                if (!first) chk("scan_hold", 32'(run), 32'(4));
                chk("scan_order", 32'(an), 32'({prev[1:0], prev[2]}));
                first = 1'b0;
                prev  = an;
                run   = 1;
                ntrans++;
            end
        end
        chk("scan_transitions", 32'(ntrans >= 6), 32'(1));

        // 1023 wraps to 023 with overflow
        do_load(10'd1023, 1'b1, {LZ, 7'h5B, 7'h4F}, 1'b1);
        wait_drain();

        // 5, then a dropped load of 999 while busy
        do_load(10'd5, 1'b0, {LZ, LZ, 7'h6D}, 1'b1);
        repeat (2) @(negedge clk);
        chk("busy_during_shift", 32'(busy), 32'(1));
        num  = 10'd999;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_drain();

        // 512 aborted by reset four cycles into the shift
        do_load(10'd512, 1'b0, '0, 1'b0);
        repeat (4) @(negedge clk);
        chk("busy_before_abort", 32'(busy), 32'(1));
        rst_n = 1'b0;
        #1;
        chk("abort_outputs", 32'({busy, done, overflow, seg, an}), 32'(0));
        repeat (2) @(negedge clk);
        chk("held_reset_outputs", 32'({busy, done, overflow, seg, an}), 32'(0));
        rst_n = 1'b1;
        repeat (14) begin
            @(negedge clk);
            chk("post_reset_blank", 32'({busy, done, overflow, seg, an}), 32'(0));
        end

        // 42 after reset
        do_load(10'd42, 1'b0, {LZ, 7'h66, 7'h5B}, 1'b1);
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
